// File: rtl/ibex_irq_arbiter.sv
// rtl/ibex_irq_arbiter.sv - interrupt pending/enable tracking and fixed-priority selection
// Optional input synchronizer: define IBEX_IRQ_SYNC_EN.
module ibex_irq_arbiter #(
  parameter int unsigned          NUM_IRQ    = 32,
  parameter logic [NUM_IRQ-1:0]   LEVEL_MASK = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic               irq_en_we_i,
  input  logic [NUM_IRQ-1:0] irq_en_wdata_i,
  output logic [NUM_IRQ-1:0] irq_en_o,
  output logic [NUM_IRQ-1:0] irq_pending_o,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i
);

  logic [NUM_IRQ-1:0] lines_s;
  logic [NUM_IRQ-1:0] sample_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] req;
  logic [4:0]         sel_id;

`ifdef IBEX_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_lines_i;
      sync2_q <= sync1_q;
    end
  end

  assign lines_s = sync2_q;
`else
  assign lines_s = irq_lines_i;
`endif

  // An ack naming an out-of-range ID never matches any loop index, so it is ignored.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (LEVEL_MASK[i]) begin
        pending_d[i] = lines_s[i];
      end else begin
        pending_d[i] = (lines_s[i] & ~sample_q[i]) |
                       (pending_q[i] & ~(irq_ack_i && (irq_ack_id_i == 5'(i))));
      end
    end
  end

  assign req = pending_q & en_q;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_id = 5'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      pending_q <= '0;
      en_q      <= '0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
    end else begin
      sample_q  <= lines_s;
      pending_q <= pending_d;
      if (irq_en_we_i) begin
        en_q <= irq_en_wdata_i;
      end
      irq_o    <= |req;
      irq_id_o <= sel_id;
    end
  end

  assign irq_en_o      = en_q;
  assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// tb/tb_ibex_irq_arbiter.sv - vector table with scoreboard plus hand sequences for ibex_irq_arbiter
module tb_ibex_irq_arbiter;

`ifdef IBEX_IRQ_SYNC_EN
  localparam int AHEAD = 2;
`else
  localparam int AHEAD = 0;
`endif
  localparam int LAT = AHEAD + 2;

  typedef struct {
    logic [31:0] lines;
    logic        we;
    logic [31:0] wdata;
    logic        ack;
    logic [4:0]  ack_id;
    logic        exp_irq;
    logic [4:0]  exp_id;
    logic [31:0] exp_pend;
    logic [31:0] exp_en;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] lines32, wd32, en32, pend32;
  logic        we32, ack32, irq32;
  logic [4:0]  ackid32, id32;

  logic [7:0]  lines8, wd8, en8, pend8;
  logic        we8, ack8, irq8;
  logic [4:0]  ackid8, id8;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  ibex_irq_arbiter #(.NUM_IRQ(32), .LEVEL_MASK(32'h0000_0010)) dut32 (
    .clk(clk), .rst_n(rst_n), .irq_lines_i(lines32),
    .irq_en_we_i(we32), .irq_en_wdata_i(wd32), .irq_en_o(en32),
    .irq_pending_o(pend32), .irq_o(irq32), .irq_id_o(id32),
    .irq_ack_i(ack32), .irq_ack_id_i(ackid32)
  );

  ibex_irq_arbiter #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .irq_lines_i(lines8),
    .irq_en_we_i(we8), .irq_en_wdata_i(wd8), .irq_en_o(en8),
    .irq_pending_o(pend8), .irq_o(irq8), .irq_id_o(id8),
    .irq_ack_i(ack8), .irq_ack_id_i(ackid8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] l, input logic w, input logic [31:0] wd,
                     input logic a, input logic [4:0] aid, input logic ei,
                     input logic [4:0] eid, input logic [31:0] ep, input logic [31:0] ee);
    vec_t v;
    v.lines = l; v.we = w; v.wdata = wd; v.ack = a; v.ack_id = aid;
    v.exp_irq = ei; v.exp_id = eid; v.exp_pend = ep; v.exp_en = ee;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t e;
    int   n;
    lines32 = '0; we32 = 1'b0; wd32 = '0; ack32 = 1'b0; ackid32 = '0;
    lines8  = '0; we8  = 1'b0; wd8  = '0; ack8  = 1'b0; ackid8  = '0;

    // Each row: inputs for one cycle, outputs expected just after that cycle's edge.
    add(32'h0,    1, 32'hFFFF_FFFF, 0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h20,   0, 0,             0, 0,  0, 0,  32'h20,   32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 5,  32'h20,   32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 5,  1, 5,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h208,  0, 0,             0, 0,  0, 0,  32'h208,  32'hFFFF_FFFF);
    add(32'h208,  0, 0,             0, 0,  1, 3,  32'h208,  32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 3,  1, 3,  32'h200,  32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 9,  32'h200,  32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 9,  1, 9,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h80,   1, 32'hFFFF_FF7F, 0, 0,  0, 0,  32'h80,   32'hFFFF_FF7F);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h80,   32'hFFFF_FF7F);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h80,   32'hFFFF_FF7F);
    add(32'h0,    1, 32'hFFFF_FFFF, 0, 0,  0, 0,  32'h80,   32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 7,  32'h80,   32'hFFFF_FFFF);
    add(32'h0,    1, 32'hFFFF_FFFE, 1, 7,  1, 7,  32'h0,    32'hFFFF_FFFE);
    add(32'h0,    1, 32'hFFFF_FFFF, 0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h4,    0, 0,             0, 0,  0, 0,  32'h4,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 2,  32'h4,    32'hFFFF_FFFF);
    add(32'h4,    0, 0,             1, 2,  1, 2,  32'h4,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 2,  32'h4,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 2,  1, 2,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h10,   0, 0,             0, 0,  0, 0,  32'h10,   32'hFFFF_FFFF);
    add(32'h10,   0, 0,             1, 4,  1, 4,  32'h10,   32'hFFFF_FFFF);
    add(32'h10,   0, 0,             0, 0,  1, 4,  32'h10,   32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 4,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h1000, 0, 0,             0, 0,  0, 0,  32'h1000, 32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 20, 1, 12, 32'h1000, 32'hFFFF_FFFF);
    add(32'h1,    0, 0,             0, 0,  1, 12, 32'h1001, 32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 12, 1, 0,  32'h1,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  1, 0,  32'h1,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             1, 0,  1, 0,  32'h0,    32'hFFFF_FFFF);
    add(32'h0,    0, 0,             0, 0,  0, 0,  32'h0,    32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    #1;
    check("reset irq", {31'b0, irq32}, 32'h0);
    check("reset id", {27'b0, id32}, 32'h0);
    check("reset en", en32, 32'h0);
    check("reset pend", pend32, 32'h0);
    rst_n = 1'b1;

    // With the synchronizer, lines are driven AHEAD cycles early so rows stay aligned.
    for (int k = 0; k < tbl.size(); k++) begin
      lines32 = (k + AHEAD < tbl.size()) ? tbl[k + AHEAD].lines : 32'h0;
      we32    = tbl[k].we;
      wd32    = tbl[k].wdata;
      ack32   = tbl[k].ack;
      ackid32 = tbl[k].ack_id;
      exp_q.push_back(tbl[k]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("row%0d irq", k), {31'b0, irq32}, {31'b0, e.exp_irq});
      check($sformatf("row%0d id", k), {27'b0, id32}, {27'b0, e.exp_id});
      check($sformatf("row%0d pend", k), pend32, e.exp_pend);
      check($sformatf("row%0d en", k), en32, e.exp_en);
    end
    lines32 = '0; we32 = 1'b0; ack32 = 1'b0;

    we8 = 1'b1; wd8 = 8'hFF;
    @(posedge clk);
    #1;
    we8 = 1'b0;
    check("dut8 en", {24'b0, en8}, 32'hFF);

    lines8 = 8'h02;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) lines8 = 8'h00;
      if (irq8) break;
    end
    check("dut8 latency", n, LAT);
    check("dut8 id", {27'b0, id8}, 32'h1);

    ack8 = 1'b1; ackid8 = 5'd31;
    @(posedge clk);
    #1;
    ack8 = 1'b0;
    @(posedge clk);
    #1;
    check("ack31 irq", {31'b0, irq8}, 32'h1);
    check("ack31 id", {27'b0, id8}, 32'h1);
    check("ack31 pend", {24'b0, pend8}, 32'h2);

    #2;
    rst_n = 1'b0;
    #1;
    check("async irq8", {31'b0, irq8}, 32'h0);
    check("async id8", {27'b0, id8}, 32'h0);
    check("async pend8", {24'b0, pend8}, 32'h0);
    check("async en8", {24'b0, en8}, 32'h0);
    check("async en32", en32, 32'h0);
    check("async irq32", {31'b0, irq32}, 32'h0);
    #2;
    rst_n = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    check("post reset irq8", {31'b0, irq8}, 32'h0);
    check("post reset pend8", {24'b0, pend8}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
